router_1xn: RTL and testbench
=============================

Name: router_1xn

Overview:
Parametrised packet router: one byte-serial input port, NUM_CH output channels, each with its own FIFO. Successor to the fixed 1x3 router, with the same packet format: header {len, addr}, then len payload bytes, then an XOR parity byte. Adds a configurable channel count, FIFO depth and data width, length checking, invalid-address drop, and a per-channel read-timeout flush. Sits between the packet source and NUM_CH independent consumers.

Parameters:
DATA_W, 8, byte width; header = {len[DATA_W-ADDR_W-1:0], addr[ADDR_W-1:0]}
NUM_CH, 3, number of output channels (2..16); ADDR_W = clog2(NUM_CH), minimum 1
FIFO_DEPTH, 16, entries per channel FIFO (power of 2, >=4)
TIMEOUT, 30, cycles a channel may hold valid_out high without read_en before it is flushed

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  asynchronous active-low reset
data_in  in  DATA_W  header/payload/parity byte
pkt_valid  in  1  high for header and payload bytes; low on the parity byte
read_en  in  NUM_CH  per-channel pop request
data_out  out  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]; shows FIFO head
valid_out  out  NUM_CH  channel FIFO i non-empty (committed data, see Optional Feature)
busy  out  1  input stall; data_in is ignored while high
error  out  1  last packet had a parity error, length error or invalid address

Behaviour:
- Reset (rstn=0, async): FSM to IDLE; all FIFOs empty; data_out=0, valid_out=0, busy=0, error=0; timeout counters cleared. A reset mid-packet discards the partial packet.
- A byte is accepted on a posedge only when busy=0.
- FSM states:
  - IDLE: pkt_valid=1 → decode the header.
    - addr>=NUM_CH → DROP.
    - Target FIFO non-empty → WAIT (busy=1, byte not consumed).
    - Otherwise write the header, latch len/addr, clear the running parity, clear error → LOAD.
  - WAIT: busy=1 until the target FIFO is empty, then behave as IDLE with the held header.
  - LOAD: each accepted byte is written to the FIFO and XORed into the running parity.
    - pkt_valid=1 → payload byte; payload counter increments.
    - pkt_valid=0 → parity byte; written, then → CHECK.
    - Target FIFO full → FULL.
  - FULL: busy=1, no write, until a slot frees; then → LOAD. The byte present on data_in is written on the exit cycle.
  - CHECK: one cycle, busy=1. error=1 if (received parity != header XOR payload) or (payload count != len). Then → IDLE.
  - DROP: consumes bytes with busy=0 and writes nothing, until the byte with pkt_valid=0 arrives; then error=1 and → IDLE.
- error holds its value until the next valid header is accepted.
- len=0 is legal: header then parity, 2 bytes total.
- FIFO read: read_en[i]=1 with valid_out[i]=1 pops on posedge; data_out[i] shows the new head the same cycle as the pop.
  - read_en on an empty FIFO is ignored.
  - Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
- Timeout: counter i increments each cycle valid_out[i]=1 and read_en[i]=0, and clears on read_en[i]=1 or when empty.
  - Reaching TIMEOUT flushes FIFO i on the next edge and sets valid_out[i]=0.
  - If the input is mid-write to channel i, the FSM → DROP for the remainder of the packet and error=1.
- Pointers are clog2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB compare; wrap-around is natural.

Optional Feature:
ROUTER_ERR_DROP_EN
- Defined: store-and-forward. Each FIFO keeps a commit pointer captured at header write.
  - valid_out counts committed bytes only.
  - On CHECK error the write pointer rewinds to the commit pointer, so the whole packet vanishes; on success the commit pointer advances to the write pointer.
  - A packet larger than FIFO_DEPTH bytes cannot commit; it is dropped with error=1.
- Undefined: cut-through. Bytes are visible to the reader as soon as written; errored packets are still delivered and only error flags them.

Test Plan:
1. NUM_CH=3, 14-byte payload to addr 0, read_en[0] held high → 16 bytes on data_out[7:0] in order, header 0x38, correct parity, error=0, valid_out[0] falls after the 16th pop.
2. Same packet with the parity byte XOR 0x01 → error=1 after CHECK. Without the macro, 16 bytes are delivered; with ROUTER_ERR_DROP_EN, valid_out[0] never rises.
3. 20-byte payload to addr 2, FIFO_DEPTH=16, no reads → busy=1 when the FIFO is full after 16 writes. Raising read_en[2] resumes writing; all 22 bytes arrive (non-macro build).
4. 8-byte payload to addr 1, never read → valid_out[1] drops exactly TIMEOUT=30 cycles after it rose; a following packet to addr 1 is accepted with no WAIT.
5. NUM_CH=3, header addr 3, 5-byte payload → busy stays 0, no valid_out rises, error=1 after the parity byte.
6. A header to addr 0 while FIFO 0 holds 4 bytes → busy=1 until 4 pops, then the header is accepted. Apply rstn=0 mid-payload → all outputs 0 immediately.

Source files
------------

// File: rtl/router_1xn.sv
// router_1xn: one byte-serial input routed to NUM_CH channel FIFOs.
// Define ROUTER_ERR_DROP_EN for store-and-forward (errored packets vanish).
module router_1xn #(
   parameter int DATA_W     = 8,
   parameter int NUM_CH     = 3,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 30
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     pkt_valid,
   input  logic [NUM_CH-1:0]        read_en,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic [NUM_CH-1:0]        valid_out,
   output logic                     busy,
   output logic                     error
);
   localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
   localparam int LEN_W  = DATA_W - ADDR_W;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int PW     = AW + 1;
   localparam int CW     = $clog2(TIMEOUT + 1);
   localparam int NW     = LEN_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_LOAD, S_FULL, S_CHECK, S_DROP
   } state_t;

   state_t state, state_nx;

   logic [DATA_W-1:0] mem [NUM_CH][FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr [NUM_CH];
   logic [PW-1:0]     rd_ptr [NUM_CH];
   logic [CW-1:0]     tcnt [NUM_CH];
`ifdef ROUTER_ERR_DROP_EN
   logic [PW-1:0]     cm_ptr [NUM_CH];
   logic              rewind, commit;
`endif

   logic [NUM_CH-1:0] empty, full, flush, pop;
   logic [DATA_W-1:0] hdr_q, hdr, par_q, rx_par_q, wr_data;
   logic [ADDR_W-1:0] tgt_q, h_addr, wr_ch;
   logic [LEN_W-1:0]  len_q, h_len;
   logic [NW-1:0]     cnt_q;
   logic              h_ok, h_go, h_hold;
   logic              full_tgt, flush_tgt, stall, chk_bad;
   logic              wr_en, pay_acc, par_acc, chk, set_err;

   // Header comes from the input, or from the hold register while waiting.
   assign hdr    = (state == S_WAIT) ? hdr_q : data_in;
   assign h_addr = hdr[ADDR_W-1:0];
   assign h_len  = hdr[DATA_W-1:ADDR_W];
   assign h_ok   = 32'(h_addr) < 32'(NUM_CH);
   assign h_go   = (state == S_WAIT || (state == S_IDLE && pkt_valid))
                   && h_ok && empty[h_addr];
   assign h_hold = state == S_IDLE && pkt_valid && h_ok && !empty[h_addr];

   assign full_tgt  = full[tgt_q];
   assign flush_tgt = flush[tgt_q];
   assign chk_bad   = (rx_par_q != par_q) || (cnt_q != {1'b0, len_q});

`ifdef ROUTER_ERR_DROP_EN
   assign stall = 1'b0;
`else
   assign stall = (state == S_LOAD || state == S_FULL) && full_tgt;
`endif
   assign busy = (state == S_WAIT) || (state == S_CHECK) || stall;

   // Per-channel status, timeout strobe and head-of-FIFO output.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         empty[i] = wr_ptr[i] == rd_ptr[i];
         full[i]  = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
`ifdef ROUTER_ERR_DROP_EN
         valid_out[i] = cm_ptr[i] != rd_ptr[i];
`else
         valid_out[i] = !empty[i];
`endif
         pop[i]   = read_en[i] && valid_out[i];
         flush[i] = valid_out[i] && !read_en[i] &&
                    (tcnt[i] == CW'(TIMEOUT - 1));
         data_out[i*DATA_W +: DATA_W] =
            valid_out[i] ? mem[i][rd_ptr[i][AW-1:0]] : '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (pkt_valid) begin
               if (!h_ok)     state_nx = S_DROP;
               else if (h_go) state_nx = S_LOAD;
               else           state_nx = S_WAIT;
            end
         end
         S_WAIT: if (h_go) state_nx = S_LOAD;
         S_LOAD, S_FULL: begin
            if (flush_tgt)
               state_nx = (stall || pkt_valid) ? S_DROP : S_IDLE;
            else if (full_tgt)
`ifdef ROUTER_ERR_DROP_EN
               state_nx = pkt_valid ? S_DROP : S_IDLE;
`else
               state_nx = S_FULL;
`endif
            else
               state_nx = pkt_valid ? S_LOAD : S_CHECK;
         end
         S_CHECK: state_nx = S_IDLE;
         S_DROP:  if (!pkt_valid) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: FIFO write strobe and datapath controls.
   always_comb begin
      wr_en   = 1'b0;
      wr_ch   = tgt_q;
      wr_data = data_in;
      pay_acc = 1'b0;
      par_acc = 1'b0;
      chk     = 1'b0;
      set_err = 1'b0;
`ifdef ROUTER_ERR_DROP_EN
      rewind  = 1'b0;
      commit  = 1'b0;
`endif
      if (h_go) begin
         wr_en   = 1'b1;
         wr_ch   = h_addr;
         wr_data = hdr;
      end
      unique case (state)
         S_LOAD, S_FULL: begin
            if (flush_tgt) begin
               set_err = 1'b1;
`ifdef ROUTER_ERR_DROP_EN
               rewind  = 1'b1;
`endif
            end else if (!full_tgt) begin
               wr_en   = 1'b1;
               pay_acc = pkt_valid;
               par_acc = !pkt_valid;
            end
`ifdef ROUTER_ERR_DROP_EN
            else begin
               rewind  = 1'b1;
               set_err = 1'b1;
            end
`endif
         end
         S_CHECK: begin
            chk = 1'b1;
`ifdef ROUTER_ERR_DROP_EN
            rewind = chk_bad;
            commit = !chk_bad;
`endif
         end
         S_DROP:  set_err = !pkt_valid;
         default: ;
      endcase
   end

   // Packet context: held header, length, payload count, parity, error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hdr_q    <= '0;
         tgt_q    <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         par_q    <= '0;
         rx_par_q <= '0;
         error    <= 1'b0;
      end else begin
         if (h_hold) hdr_q <= data_in;
         if (h_go) begin
            tgt_q <= h_addr;
            len_q <= h_len;
            cnt_q <= '0;
            par_q <= hdr;
            error <= 1'b0;
         end
         if (pay_acc) begin
            if (cnt_q != '1) cnt_q <= cnt_q + NW'(1);
            par_q <= par_q ^ data_in;
         end
         if (par_acc) rx_par_q <= data_in;
         if (set_err || (chk && chk_bad)) error <= 1'b1;
      end
   end

   // FIFO pointers and read-timeout counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            tcnt[i]   <= '0;
`ifdef ROUTER_ERR_DROP_EN
            cm_ptr[i] <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && wr_ch == ADDR_W'(i))
               wr_ptr[i] <= wr_ptr[i] + PW'(1);
`ifdef ROUTER_ERR_DROP_EN
            if (rewind && tgt_q == ADDR_W'(i))
               wr_ptr[i] <= cm_ptr[i];
            if (commit && tgt_q == ADDR_W'(i))
               cm_ptr[i] <= wr_ptr[i];
`endif
            if (flush[i])
`ifdef ROUTER_ERR_DROP_EN
               rd_ptr[i] <= cm_ptr[i];
`else
               rd_ptr[i] <= wr_ptr[i];
`endif
            else if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + PW'(1);
            if (!valid_out[i] || read_en[i] || flush[i])
               tcnt[i] <= '0;
            else
               tcnt[i] <= tcnt[i] + CW'(1);
         end
      end
   end

   // FIFO storage; contents need no reset since pointers qualify them.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ch][wr_ptr[wr_ch][AW-1:0]] <= wr_data;
   end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed vectors for router_1xn (NUM_CH=3, depth 16).
// Delivery, parity error, full stall, timeout, bad address, wait, reset.
`timescale 1ns/1ps
module tb_router_1xn;
   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  data_in;
   logic        pkt_valid;
   logic [2:0]  read_en;
   logic [23:0] data_out;
   logic [2:0]  valid_out;
   logic        busy;
   logic        error;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int t_rise = -1;
   int t_fall = -1;
   int busy_cnt = 0;
   int vld_cnt = 0;
   logic v1_d = 1'b0;
   logic [7:0] q0[$], q1[$], q2[$];
   int s, b, v;

   router_1xn #(
      .DATA_W(8), .NUM_CH(3), .FIFO_DEPTH(16), .TIMEOUT(30)
   ) dut (
      .clk(clk), .rstn(rstn), .data_in(data_in),
      .pkt_valid(pkt_valid), .read_en(read_en),
      .data_out(data_out), .valid_out(valid_out),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   // Monitor: record popped bytes, busy/valid activity, ch1 valid edges.
   always @(negedge clk) begin
      cyc++;
      if (rstn) begin
         if (valid_out[0] && read_en[0]) q0.push_back(data_out[7:0]);
         if (valid_out[1] && read_en[1]) q1.push_back(data_out[15:8]);
         if (valid_out[2] && read_en[2]) q2.push_back(data_out[23:16]);
         if (busy) busy_cnt++;
         if (|valid_out) vld_cnt++;
      end
      if (valid_out[1] && !v1_d) t_rise = cyc;
      if (!valid_out[1] && v1_d) t_fall = cyc;
      v1_d = valid_out[1];
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] bt, input logic pv);
      int n = 0;
      data_in   = bt;
      pkt_valid = pv;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) check("busy_timeout", busy, 0);
      @(posedge clk);
      #1;
      data_in   = '0;
      pkt_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] h, input logic [7:0] first,
                           input int n, input logic [7:0] par);
      send_byte(h, 1'b1);
      for (int k = 0; k < n; k++) send_byte(8'(first + 8'(k)), 1'b1);
      send_byte(par, 1'b0);
   endtask

   initial begin
      rstn      = 1'b0;
      data_in   = '0;
      pkt_valid = 1'b0;
      read_en   = '0;
      idle(3);
      check("rst_valid", 32'(valid_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(error), 0);
      check("rst_dout", 32'(data_out), 0);
      rstn = 1'b1;
      idle(2);

      // 14-byte payload to ch0, read continuously
      read_en = 3'b001;
      s = q0.size();
      send_pkt(8'h38, 8'h01, 14, 8'h37);
      idle(4);
      check("t1_count", q0.size() - s, 16);
      check("t1_hdr", q0[s], 8'h38);
      for (int k = 0; k < 14; k++) check("t1_pay", q0[s+1+k], k + 1);
      check("t1_par", q0[s+15], 8'h37);
      check("t1_err", 32'(error), 0);
      check("t1_vld", 32'(valid_out[0]), 0);

      // same packet, bad parity
      s = q0.size();
      send_pkt(8'h38, 8'h01, 14, 8'h36);
      idle(4);
      check("t2_err", 32'(error), 1);
`ifdef ROUTER_ERR_DROP_EN
      check("t2_count", q0.size() - s, 0);
`else
      check("t2_count", q0.size() - s, 16);
      check("t2_par", q0[s+15], 8'h36);
`endif
      read_en = '0;
      idle(2);

`ifndef ROUTER_ERR_DROP_EN
      // 20-byte payload to ch2 fills the FIFO, then drains
      s = q2.size();
      send_byte(8'h52, 1'b1);
      for (int k = 0; k < 15; k++) send_byte(8'(8'hA0 + 8'(k)), 1'b1);
      check("t3_busy_full", 32'(busy), 1);
      check("t3_head", 32'(data_out[23:16]), 8'h52);
      data_in   = 8'hAF;
      pkt_valid = 1'b1;
      idle(3);
      check("t3_busy_hold", 32'(busy), 1);
      read_en[2] = 1'b1;
      for (int k = 15; k < 20; k++) send_byte(8'(8'hA0 + 8'(k)), 1'b1);
      send_byte(8'h52, 1'b0);
      idle(25);
      check("t3_count", q2.size() - s, 22);
      check("t3_hdr", q2[s], 8'h52);
      check("t3_b16", q2[s+16], 8'hAF);
      check("t3_par", q2[s+21], 8'h52);
      check("t3_err", 32'(error), 0);
      read_en = '0;
      idle(2);
`endif

      // 8-byte payload to ch1 never read: timeout flush
      send_pkt(8'h21, 8'h11, 8, 8'h29);
      idle(45);
      check("t4_timeout", t_fall - t_rise, 30);
      check("t4_vld", 32'(valid_out[1]), 0);
      check("t4_err", 32'(error), 0);
      s = q1.size();
      send_byte(8'h01, 1'b1);
      check("t4_nowait", 32'(busy), 0);
      send_byte(8'h01, 1'b0);
      idle(2);
      check("t4_err2", 32'(error), 0);
      read_en[1] = 1'b1;
      idle(4);
      read_en = '0;
      check("t4_count", q1.size() - s, 2);
      idle(2);

      // invalid address 3: silently dropped, error flagged
      b = busy_cnt;
      v = vld_cnt;
      send_pkt(8'h17, 8'h50, 5, 8'h00);
      idle(2);
      check("t5_busy", busy_cnt - b, 0);
      check("t5_vld", vld_cnt - v, 0);
      check("t5_err", 32'(error), 1);

      // header waits for ch0 to drain its 4 bytes
      send_pkt(8'h08, 8'hC1, 2, 8'h0B);
      idle(2);
      check("t6_vld", 32'(valid_out[0]), 1);
      s = q0.size();
      send_byte(8'h04, 1'b1);
      idle(2);
      check("t6_wait", 32'(busy), 1);
      read_en[0] = 1'b1;
      send_byte(8'hD1, 1'b1);
      send_byte(8'hD5, 1'b0);
      idle(4);
      check("t6_count", q0.size() - s, 7);
      check("t6_old", q0[s+3], 8'h0B);
      check("t6_hdr", q0[s+4], 8'h04);
      check("t6_par", q0[s+6], 8'hD5);
      check("t6_err", 32'(error), 0);

      // reset mid-payload
      read_en = '0;
      send_byte(8'h10, 1'b1);
      send_byte(8'hE1, 1'b1);
      send_byte(8'hE2, 1'b1);
`ifndef ROUTER_ERR_DROP_EN
      check("t7_pre_vld", 32'(valid_out[0]), 1);
`endif
      data_in   = 8'hE3;
      pkt_valid = 1'b1;
      #2 rstn = 1'b0;
      #1;
      check("t7_vld", 32'(valid_out), 0);
      check("t7_dout", 32'(data_out), 0);
      check("t7_busy", 32'(busy), 0);
      check("t7_err", 32'(error), 0);
      pkt_valid = 1'b0;
      data_in   = '0;
      @(negedge clk);
      rstn = 1'b1;
      idle(2);

      // recovery: len 0 packet to ch2
      read_en[2] = 1'b1;
      s = q2.size();
      send_pkt(8'h02, 8'h00, 0, 8'h02);
      idle(4);
      check("t8_count", q2.size() - s, 2);
      check("t8_hdr", q2[s], 8'h02);
      check("t8_err", 32'(error), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
